scan_decoder: RTL and testbench
===============================

# scan_decoder

Parametrised, registered active-low N-to-2^N line decoder with a built-in display-scan engine. It generalises the classic 3-to-8 decoder: a three-input enable gate, plus a free-running scan mode that cycles the active output with programmable dwell and inter-digit blanking. In direct mode it decodes an external address. It sits between the digital-clock time/segment logic and the multiplexed seven-segment digit commons.

## Interface
Parameters:
- SEL_W, 3: select/address width.
- NUM_OUT, 8: number of decoded outputs. Legal range 2..2^SEL_W.
- DWELL, 1000: clock cycles each output stays asserted in scan mode. Must be ≥1.
- BLANK, 2: cycles with all outputs deasserted between consecutive outputs in scan mode. Must be ≥0.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- e1  in  1  enable, active-high.
- e2_n  in  1  enable, active-low.
- e3_n  in  1  enable, active-low.
- mode  in  1  0 = scan, 1 = direct.
- addr_in  in  SEL_W  direct-mode address.
- y_n  out  NUM_OUT  registered decoded outputs, active-low, at most one low.
- cur_sel  out  SEL_W  index currently driven; valid whenever any y_n bit is low.
- frame_start  out  1  one-cycle pulse, coincident with the first cycle output 0 is driven in scan mode.

## Operation
- The block is enabled when {e1,e2_n,e3_n} equals 3'b100; any other combination means disabled.
- FSM states: IDLE, ACTIVE, GAP.
- IDLE:
  - y_n is all ones and cur_sel is 0.
  - When enabled and in scan mode, go to ACTIVE with index 0.
- ACTIVE (scan):
  - Exactly one bit, y_n[index], is low.
  - The dwell counter counts DWELL cycles.
  - On expiry, go to GAP if BLANK>0. Otherwise go directly to ACTIVE with the next index.
- GAP:
  - y_n is all ones and cur_sel holds the previous index.
  - After BLANK cycles, go to ACTIVE with the next index.
- Index update: next index = index+1, wrapping from NUM_OUT-1 to 0.
- frame_start asserts for the first ACTIVE cycle of index 0.
- Direct mode (enabled, mode=1):
  - The FSM stays in IDLE.
  - y_n[addr_in] is low, and cur_sel equals addr_in, both registered.
  - If addr_in ≥ NUM_OUT, y_n is all ones and cur_sel equals addr_in.
  - frame_start is never asserted.
- Disable at any point: on the next edge y_n goes all ones, the FSM goes to IDLE, and the counter and index clear. Re-enabling in scan mode restarts at index 0 with frame_start.
- Mode switch 1→0: the FSM enters ACTIVE with index 0 and a fresh dwell count.
- Mode switch 0→1: the next edge produces the direct decode, and the scan state is discarded.
- Counter width is $clog2(max(DWELL,BLANK)+1). The counter counts down from its load value to 1, so there are no off-by-one idle cycles.
- Illegal parameters (NUM_OUT > 2^SEL_W, NUM_OUT < 2, or DWELL < 1) are rejected by an elaboration-time check.

## Timing
- Reset values:
  - y_n is all ones.
  - cur_sel is 0.
  - frame_start is 0.
  - FSM is in IDLE and the counter is 0.
- Reset is asynchronous on assertion. Release takes effect at the first clk edge after rst_n goes high.
- Latency: every input change appears on the outputs one clk edge after it is sampled. There are no combinational paths from inputs to outputs.
- Scan period is NUM_OUT·(DWELL+BLANK) cycles. frame_start pulses at exactly this period.
- Output transitions are glitch-free: all outputs are registered, and two y_n bits are never low simultaneously, including on the ACTIVE→ACTIVE transition when BLANK=0.
- Enable and mode changes take priority over an expiring dwell/gap count in the same cycle.

## Structure
- Shared package scan_decoder_pkg holds:
  - the FSM state enum (IDLE, ACTIVE, GAP);
  - the all-ones/blank constant helper;
  - the enable-match constant 3'b100.
- One combinational sub-module, onehot_decoder_n (parameters SEL_W, NUM_OUT; inputs addr and valid; output active-low one-hot vector). It is instantiated once and fed from either the scan index or addr_in. The output register lives in scan_decoder.

## Test plan
- Reset/disable: hold rst_n=0, then release with {e1,e2_n,e3_n}=3'b000. Expect y_n=8'hFF, cur_sel=0 and frame_start=0 indefinitely.
- Scan with defaults but DWELL=4, BLANK=2: expect the y_n sequence FE×4, FF×2, FD×4, FF×2 … 7F×4, FF×2, then FE again. Expect frame_start pulses 48 cycles apart.
- BLANK=0, DWELL=1, NUM_OUT=5, SEL_W=3: expect y_n to walk 1E,1D,1B,17,0F,1E one cycle each, and never two bits low.
- Direct mode: sweep addr_in 0..7 with NUM_OUT=6. Expect y_n=~(1<<addr) one cycle later for 0..5 and all ones for 6..7; cur_sel follows addr_in.
- Mid-scan disruption:
  - Drop e1 during index 3: expect all ones on the next edge.
  - Re-enable: expect restart at index 0 with frame_start.
  - Pulse rst_n low mid-dwell: expect immediate all ones.
- Mode switch: scan at index 5, set mode=1 with addr_in=2. Expect y_n=FB next edge. Return mode to 0: expect index 0 with frame_start.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_decoder_pkg
// Description : Shared types and constants for the scan_decoder block.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // {e1, e2_n, e3_n} pattern that enables the block
    localparam logic [2:0] c_enable_match = 3'b100;

    localparam int c_max_out = 256;
    typedef logic [c_max_out-1:0] wide_vec_t;

    // All outputs deasserted; callers slice to their own output width
    function automatic wide_vec_t blank_vec();
        return '1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_decoder_onehot.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decoder_n
// Description : Combinational active-low one-hot decoder; out-of-range
//               addresses or valid=0 leave every output deasserted.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_decoder_n #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8
) (
    input  logic [SEL_W-1:0]   addr,
    input  logic               valid,
    output logic [NUM_OUT-1:0] y_n
);

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
        assign y_n[i] = ~(valid && (addr == SEL_W'(i)));
    end

endmodule
`default_nettype wire

// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : scan_decoder
// Description : Registered active-low N-to-2^N decoder with a display-scan
//               engine (programmable dwell and inter-digit blanking).
// Revision    : 1.0 - initial release
// ============================================================================
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int DWELL   = 1000,
    parameter int BLANK   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               e1,
    input  logic               e2_n,
    input  logic               e3_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   addr_in,
    output logic [NUM_OUT-1:0] y_n,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               frame_start
);

    localparam int c_cnt_max = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam wide_vec_t              c_blank_wide = blank_vec();
    localparam logic [NUM_OUT-1:0]     c_blank      = c_blank_wide[NUM_OUT-1:0];
    localparam logic [SEL_W-1:0]       c_last_idx   = SEL_W'(NUM_OUT - 1);
    localparam logic [c_cnt_w-1:0]     c_dwell_load = c_cnt_w'(DWELL);
    localparam logic [c_cnt_w-1:0]     c_blank_load = c_cnt_w'(BLANK);
    localparam logic [c_cnt_w-1:0]     c_cnt_one    = c_cnt_w'(1);

    if ((NUM_OUT < 2) || (NUM_OUT > (1 << SEL_W)) || (NUM_OUT > c_max_out)
        || (DWELL < 1) || (BLANK < 0)) begin : g_param_check
        $error("scan_decoder: illegal parameters SEL_W=%0d NUM_OUT=%0d DWELL=%0d BLANK=%0d",
               SEL_W, NUM_OUT, DWELL, BLANK);
    end

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [SEL_W-1:0]     r_idx;
    logic [NUM_OUT-1:0]   r_y_n;
    logic [SEL_W-1:0]     r_cur_sel;
    logic                 r_frame;

    logic                 w_en;
    logic                 w_cnt_expired;
    logic [SEL_W-1:0]     w_idx_inc;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [SEL_W-1:0]     w_idx_nxt;
    logic [SEL_W-1:0]     w_sel_nxt;
    logic                 w_valid_nxt;
    logic                 w_frame_nxt;
    logic [NUM_OUT-1:0]   w_dec_y_n;

    assign w_en          = ({e1, e2_n, e3_n} == c_enable_match);
    assign w_cnt_expired = (r_cnt == c_cnt_one);
    assign w_idx_inc     = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;

    // Enable and mode are resolved before the scan counter so they win
    // over an expiring dwell/gap in the same cycle.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_sel_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_frame_nxt = 1'b0;
        if (w_en && mode) begin
            w_sel_nxt   = addr_in;
            w_valid_nxt = 1'b1;
        end else if (w_en) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ACTIVE;
                    w_cnt_nxt   = c_dwell_load;
                    w_valid_nxt = 1'b1;
                    w_frame_nxt = 1'b1;
                end
                ST_ACTIVE: begin
                    if (!w_cnt_expired) begin
                        w_state_nxt = ST_ACTIVE;
                        w_cnt_nxt   = r_cnt - 1'b1;
                        w_idx_nxt   = r_idx;
                        w_valid_nxt = 1'b1;
                    end else if (BLANK > 0) begin
                        w_state_nxt = ST_GAP;
                        w_cnt_nxt   = c_blank_load;
                        w_idx_nxt   = r_idx;
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                        w_cnt_nxt   = c_dwell_load;
                        w_idx_nxt   = w_idx_inc;
                        w_valid_nxt = 1'b1;
                        w_frame_nxt = (w_idx_inc == '0);
                    end
                end
                ST_GAP: begin
                    if (!w_cnt_expired) begin
                        w_state_nxt = ST_GAP;
                        w_cnt_nxt   = r_cnt - 1'b1;
                        w_idx_nxt   = r_idx;
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                        w_cnt_nxt   = c_dwell_load;
                        w_idx_nxt   = w_idx_inc;
                        w_valid_nxt = 1'b1;
                        w_frame_nxt = (w_idx_inc == '0);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
            w_sel_nxt = w_idx_nxt;
        end
    end

    onehot_decoder_n #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_dec (
        .addr  (w_sel_nxt),
        .valid (w_valid_nxt),
        .y_n   (w_dec_y_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_y_n     <= c_blank;
            r_cur_sel <= '0;
            r_frame   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_y_n     <= w_dec_y_n;
            r_cur_sel <= w_sel_nxt;
            r_frame   <= w_frame_nxt;
        end
    end

    assign y_n         = r_y_n;
    assign cur_sel     = r_cur_sel;
    assign frame_start = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_decoder
// Description : Self-checking bench for three scan_decoder configurations
//               sharing one stimulus stream and one timeline-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_decoder;

    localparam int K_IDLE   = 0;
    localparam int K_DIRECT = 1;
    localparam int K_SCAN   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       e1 = 1'b0;
    logic       e2_n = 1'b0;
    logic       e3_n = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] addr_in = 3'd0;

    logic [7:0] ya;
    logic [4:0] yb;
    logic [5:0] yc;
    logic [2:0] sa, sb, sc;
    logic       fa, fb, fc;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model state: what the last edge decided, and time since the scan began
    int m_kind = K_IDLE;
    int m_addr = 0;
    int m_t = 0;
    bit m_scan = 1'b0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .NUM_OUT(8), .DWELL(4), .BLANK(2)) u_a (
        .clk(clk), .rst_n(rst_n), .e1(e1), .e2_n(e2_n), .e3_n(e3_n), .mode(mode),
        .addr_in(addr_in), .y_n(ya), .cur_sel(sa), .frame_start(fa));

    scan_decoder #(.SEL_W(3), .NUM_OUT(5), .DWELL(1), .BLANK(0)) u_b (
        .clk(clk), .rst_n(rst_n), .e1(e1), .e2_n(e2_n), .e3_n(e3_n), .mode(mode),
        .addr_in(addr_in), .y_n(yb), .cur_sel(sb), .frame_start(fb));

    scan_decoder #(.SEL_W(3), .NUM_OUT(6), .DWELL(3), .BLANK(1)) u_c (
        .clk(clk), .rst_n(rst_n), .e1(e1), .e2_n(e2_n), .e3_n(e3_n), .mode(mode),
        .addr_in(addr_in), .y_n(yc), .cur_sel(sc), .frame_start(fc));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_kind = K_IDLE;
            m_scan = 1'b0;
            m_t    = 0;
        end else if (!(e1 == 1'b1 && e2_n == 1'b0 && e3_n == 1'b0)) begin
            m_kind = K_IDLE;
            m_scan = 1'b0;
        end else if (mode) begin
            m_kind = K_DIRECT;
            m_addr = int'(addr_in);
            m_scan = 1'b0;
        end else begin
            m_t    = m_scan ? m_t + 1 : 0;
            m_scan = 1'b1;
            m_kind = K_SCAN;
        end
    end

    function automatic int exp_y(int n, int d, int b);
        int ones, p, pos;
        ones = (1 << n) - 1;
        p    = d + b;
        pos  = m_t % (n * p);
        if (m_kind == K_DIRECT)
            return (m_addr < n) ? (ones & ~(1 << m_addr)) : ones;
        if (m_kind == K_SCAN)
            return ((pos % p) < d) ? (ones & ~(1 << (pos / p))) : ones;
        return ones;
    endfunction

    function automatic int exp_sel(int n, int d, int b);
        if (m_kind == K_DIRECT) return m_addr;
        if (m_kind == K_SCAN)   return (m_t % (n * (d + b))) / (d + b);
        return 0;
    endfunction

    function automatic int exp_frame(int n, int d, int b);
        return (m_kind == K_SCAN && (m_t % (n * (d + b))) == 0) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a.y_n",        32'(ya), 32'(exp_y(8, 4, 2)));
        check("a.cur_sel",    32'(sa), 32'(exp_sel(8, 4, 2)));
        check("a.frame",      32'(fa), 32'(exp_frame(8, 4, 2)));
        check("b.y_n",        32'(yb), 32'(exp_y(5, 1, 0)));
        check("b.cur_sel",    32'(sb), 32'(exp_sel(5, 1, 0)));
        check("b.frame",      32'(fb), 32'(exp_frame(5, 1, 0)));
        check("c.y_n",        32'(yc), 32'(exp_y(6, 3, 1)));
        check("c.cur_sel",    32'(sc), 32'(exp_sel(6, 3, 1)));
        check("c.frame",      32'(fc), 32'(exp_frame(6, 3, 1)));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            check_all();
        end
    endtask

    task automatic set_en(input logic [2:0] en);
        {e1, e2_n, e3_n} = en;
    endtask

    initial begin
        int last_fa;
        // Reset held, then released while disabled
        set_en(3'b000);
        step(3);
        rst_n = 1'b1;
        step(6);

        // Scan: two full periods of the 8-output instance
        set_en(3'b100);
        mode = 1'b0;
        last_fa = -1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (fa) begin
                if (last_fa >= 0) check("a.frame_period", 32'(cyc - last_fa), 32'd48);
                last_fa = cyc;
            end
        end

        // Direct sweep over every address, including out-of-range ones
        mode = 1'b1;
        for (int a = 0; a < 8; a++) begin
            addr_in = 3'(a);
            step(1);
        end

        // Back to scan; drop e1 during index 3, then re-enable
        mode = 1'b0;
        step(20);
        e1 = 1'b0;
        step(1);
        e1 = 1'b1;
        step(31);

        // Mode switch at index 5, then return to scan
        mode = 1'b1;
        addr_in = 3'd2;
        step(1);
        check("a.y_n_direct2", 32'(ya), 32'h0000_00FB);
        mode = 1'b0;
        step(15);

        // Asynchronous reset pulse mid-dwell
        #2 rst_n = 1'b0;
        #1 check_all();
        check("a.y_n_async_rst", 32'(ya), 32'h0000_00FF);
        step(2);
        rst_n = 1'b1;
        step(10);

        // Randomised disruption of enables, mode and address
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 2) == 0) set_en(3'($urandom_range(0, 7)));
                else                          set_en(3'b100);
                mode = ($urandom_range(0, 3) == 0);
            end
            if (mode && $urandom_range(0, 3) == 0) addr_in = 3'($urandom_range(0, 7));
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
